// File: rtl/matmul_tile_scheduler.sv
// Walks the output tiles of one C = A x B job (m outer, n middle, k inner) and issues one array start per tile.
// Latency: accept->start 1 cycle, done->next start 1 cycle; a tile waits in ISSUE while arr_busy is high.
module matmul_tile_scheduler #(
    parameter int ARRAY_SIZE = 32,
    parameter int TILE_CNT_W = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TILE_CNT_W-1:0] cmd_m_tiles,
    input  logic [TILE_CNT_W-1:0] cmd_n_tiles,
    input  logic [TILE_CNT_W-1:0] cmd_k_tiles,
    input  logic [ADDR_W-1:0]     cmd_a_base,
    input  logic [ADDR_W-1:0]     cmd_b_base,
    input  logic [ADDR_W-1:0]     cmd_c_base,
    output logic                  arr_start,
    output logic                  arr_acc_mode,
    input  logic                  arr_busy,
    input  logic                  arr_done,
    output logic [ADDR_W-1:0]     a_tile_addr,
    output logic [ADDR_W-1:0]     b_tile_addr,
    output logic [ADDR_W-1:0]     c_tile_addr,
    output logic                  c_commit,
    output logic                  job_busy,
    output logic                  job_done,
    output logic                  job_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ARRAY_SIZE);

    state_t state, state_nxt;

    logic [TILE_CNT_W-1:0] m_cnt, n_cnt, k_cnt;
    logic [TILE_CNT_W-1:0] m_last, n_last, k_last;
    logic [ADDR_W-1:0]     a_ptr, a_row, b_ptr, b_col, b_base, c_ptr, b_kstride;
    logic                  err_flag;
    logic                  accept, zero_dim, k_end, n_end, last_tile, tile_step, active;

    assign zero_dim  = (cmd_m_tiles == '0) || (cmd_n_tiles == '0) || (cmd_k_tiles == '0);
    assign accept    = cmd_valid && (state == IDLE);
    assign k_end     = (k_cnt == k_last);
    assign n_end     = (n_cnt == n_last);
    assign last_tile = k_end && n_end && (m_cnt == m_last);
    assign tile_step = (state == WAIT) && arr_done && !last_tile;
    assign active    = (state == ISSUE) || (state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        arr_start = 1'b0;
        job_done  = 1'b0;
        job_err   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = zero_dim ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (!arr_busy) begin
                    arr_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (arr_done) state_nxt = last_tile ? FINISH : ISSUE;
            end
            FINISH: begin
                job_done  = 1'b1;
                job_err   = err_flag;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers follow the m/n/k walk by additions only: a steps linearly except when
    // k wraps inside a row, b jumps by N tiles per k step, c advances once per finished C tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= '0;
            n_cnt     <= '0;
            k_cnt     <= '0;
            m_last    <= '0;
            n_last    <= '0;
            k_last    <= '0;
            a_ptr     <= '0;
            a_row     <= '0;
            b_ptr     <= '0;
            b_col     <= '0;
            b_base    <= '0;
            c_ptr     <= '0;
            b_kstride <= '0;
            err_flag  <= 1'b0;
        end else if (accept) begin
            m_cnt     <= '0;
            n_cnt     <= '0;
            k_cnt     <= '0;
            m_last    <= cmd_m_tiles - TILE_CNT_W'(1);
            n_last    <= cmd_n_tiles - TILE_CNT_W'(1);
            k_last    <= cmd_k_tiles - TILE_CNT_W'(1);
            a_ptr     <= cmd_a_base;
            a_row     <= cmd_a_base;
            b_ptr     <= cmd_b_base;
            b_col     <= cmd_b_base;
            b_base    <= cmd_b_base;
            c_ptr     <= cmd_c_base;
            b_kstride <= ADDR_W'(cmd_n_tiles) * STRIDE;
            err_flag  <= zero_dim;
        end else if (tile_step) begin
            if (!k_end) begin
                k_cnt <= k_cnt + TILE_CNT_W'(1);
                a_ptr <= a_ptr + STRIDE;
                b_ptr <= b_ptr + b_kstride;
            end else begin
                k_cnt <= '0;
                c_ptr <= c_ptr + STRIDE;
                if (!n_end) begin
                    n_cnt <= n_cnt + TILE_CNT_W'(1);
                    a_ptr <= a_row;
                    b_col <= b_col + STRIDE;
                    b_ptr <= b_col + STRIDE;
                end else begin
                    n_cnt <= '0;
                    m_cnt <= m_cnt + TILE_CNT_W'(1);
                    a_ptr <= a_ptr + STRIDE;
                    a_row <= a_ptr + STRIDE;
                    b_col <= b_base;
                    b_ptr <= b_base;
                end
            end
        end
    end

    assign arr_acc_mode = active && (k_cnt != '0);
    assign a_tile_addr  = active ? a_ptr : '0;
    assign b_tile_addr  = active ? b_ptr : '0;
    assign c_tile_addr  = active ? c_ptr : '0;
    assign c_commit     = (state == WAIT) && k_end;
    assign job_busy     = active;
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: a behavioural array-controller model plus a nested-loop tile reference.
module tb_matmul_tile_scheduler;
    localparam int AS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_m_tiles, cmd_n_tiles, cmd_k_tiles;
    logic [15:0] cmd_a_base, cmd_b_base, cmd_c_base;
    logic        arr_start, arr_acc_mode, arr_busy, arr_done;
    logic [15:0] a_tile_addr, b_tile_addr, c_tile_addr;
    logic        c_commit, job_busy, job_done, job_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m_tiles(cmd_m_tiles), .cmd_n_tiles(cmd_n_tiles), .cmd_k_tiles(cmd_k_tiles),
        .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_c_base(cmd_c_base),
        .arr_start(arr_start), .arr_acc_mode(arr_acc_mode),
        .arr_busy(arr_busy), .arr_done(arr_done),
        .a_tile_addr(a_tile_addr), .b_tile_addr(b_tile_addr), .c_tile_addr(c_tile_addr),
        .c_commit(c_commit), .job_busy(job_busy), .job_done(job_done), .job_err(job_err)
    );

    typedef struct {
        int          m, n, k;
        logic [15:0] a, b, c;
        int          stall0, maxlat;
        bit          hold, immediate;
        int          exp_starts;
        bit          exp_err;
    } job_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_start_acc"}, {arr_start, arr_acc_mode}, 0);
        chk({tag, "_addrs"}, a_tile_addr | b_tile_addr | c_tile_addr, 0);
        chk({tag, "_flags"}, {c_commit, job_busy, job_done, job_err}, 0);
    endtask

    function automatic job_t mk(input int m, n, k, input logic [15:0] a, b, c,
                                input int stall0, maxlat, input bit hold, immediate);
        job_t j;
        j.m = m; j.n = n; j.k = k; j.a = a; j.b = b; j.c = c;
        j.stall0 = stall0; j.maxlat = maxlat; j.hold = hold; j.immediate = immediate;
        j.exp_starts = m * n * k;
        j.exp_err = (m == 0) || (n == 0) || (k == 0);
        return j;
    endfunction

    // Drives one job, plays the array controller, and checks every tile against the reference order.
    task automatic run_job(input job_t j, output int starts, output bit err_seen);
        logic [15:0] ea[$], eb[$], ec[$];
        bit          eacc[$], ecom[$];
        int          idx, cd, stall, next_start, jd_exp, commits;
        bit          accepted, finished, zero;
        idx = 0; cd = 0; stall = 0; next_start = -1; jd_exp = -1; commits = 0;
        accepted = 0; finished = 0; starts = 0; err_seen = 0;
        zero = (j.m == 0) || (j.n == 0) || (j.k == 0);
        if (!zero)
            for (int mm = 0; mm < j.m; mm++)
                for (int nn = 0; nn < j.n; nn++)
                    for (int kk = 0; kk < j.k; kk++) begin
                        ea.push_back(16'(j.a + (mm * j.k + kk) * AS));
                        eb.push_back(16'(j.b + (kk * j.n + nn) * AS));
                        ec.push_back(16'(j.c + (mm * j.n + nn) * AS));
                        eacc.push_back(kk != 0);
                        ecom.push_back(kk == j.k - 1);
                    end
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                cmd_m_tiles = 8'(j.m); cmd_n_tiles = 8'(j.n); cmd_k_tiles = 8'(j.k);
                cmd_a_base = j.a; cmd_b_base = j.b; cmd_c_base = j.c;
            end
            cmd_valid = accepted ? j.hold : 1'b1;
            arr_done = 1'b0;
            arr_busy = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) arr_done = 1'b1;
                else         arr_busy = 1'b1;
            end else if (stall > 0) begin
                stall--;
                arr_busy = 1'b1;
            end
            #1;
            if (!accepted) begin
                if (cmd_ready) begin
                    accepted = 1;
                    stall = j.stall0;
                    if (zero) jd_exp = cyc + 1;
                    else      next_start = cyc + 1 + j.stall0;
                    if (j.immediate) chk("ready_first_idle", cyc, 0);
                end
                continue;
            end
            chk("start_timing", arr_start, cyc == next_start);
            chk("job_done_timing", job_done, cyc == jd_exp);
            if (arr_start) begin
                chk("start_while_busy", arr_busy, 0);
                chk("job_busy", job_busy, 1);
                if (idx < ea.size()) begin
                    chk("a_addr", a_tile_addr, ea[idx]);
                    chk("b_addr", b_tile_addr, eb[idx]);
                    chk("c_addr", c_tile_addr, ec[idx]);
                    chk("acc_mode", arr_acc_mode, eacc[idx]);
                end else begin
                    chk("extra_start", idx, ea.size());
                end
                idx++;
                starts++;
                cd = 1 + $urandom_range(j.maxlat, 0);
                next_start = -1;
            end
            if (arr_done && idx > 0 && idx <= ea.size()) begin
                chk("commit", c_commit, ecom[idx-1]);
                if (c_commit) commits++;
                chk("a_stable", a_tile_addr, ea[idx-1]);
                chk("c_stable", c_tile_addr, ec[idx-1]);
                if (idx == ea.size()) jd_exp = cyc + 1;
                else begin
                    stall = $urandom_range(2, 0);
                    next_start = cyc + 1 + stall;
                end
            end
            if (job_done) begin
                finished = 1;
                err_seen = job_err;
            end
        end
        if (!finished) chk("job_timeout", 0, 1);
        chk("commits", commits, zero ? 0 : j.m * j.n);
    endtask

    job_t tbl[8];
    job_t rj;
    int   st;
    bit   er;

    initial begin
        tbl[0] = mk(1, 1, 1, 16'h0100, 16'h0200, 16'h0300, 0, 0, 0, 0);
        tbl[1] = mk(1, 1, 3, 16'h1000, 16'h2000, 16'h3000, 0, 1, 0, 0);
        tbl[2] = mk(2, 2, 2, 16'h4000, 16'h5000, 16'h6000, 0, 2, 0, 0);
        tbl[3] = mk(2, 2, 0, 16'h0010, 16'h0020, 16'h0030, 0, 0, 0, 0);
        tbl[4] = mk(1, 2, 3, 16'hFFF0, 16'hFFC0, 16'hFFE0, 5, 1, 0, 0);
        tbl[5] = mk(0, 3, 1, 16'h0040, 16'h0050, 16'h0060, 0, 0, 0, 0);
        tbl[6] = mk(3, 1, 2, 16'h0800, 16'h0900, 16'h0A00, 1, 1, 1, 0);
        tbl[7] = mk(2, 3, 1, 16'h1234, 16'h2345, 16'h3456, 0, 0, 0, 1);

        rst_n = 1'b0; cmd_valid = 1'b0; arr_busy = 1'b0; arr_done = 1'b0;
        cmd_m_tiles = '0; cmd_n_tiles = '0; cmd_k_tiles = '0;
        cmd_a_base = '0; cmd_b_base = '0; cmd_c_base = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i], st, er);
            chk("tbl_starts", st, tbl[i].exp_starts);
            chk("tbl_err", er, tbl[i].exp_err);
        end

        // Reset in the middle of a tile: everything drops, the next job restarts at tile (0,0,0).
        @(negedge clk);
        cmd_m_tiles = 8'd2; cmd_n_tiles = 8'd2; cmd_k_tiles = 8'd2;
        cmd_a_base = 16'h0700; cmd_b_base = 16'h0800; cmd_c_base = 16'h0900;
        cmd_valid = 1'b1; arr_busy = 1'b0; arr_done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 chk("rst_seq_start", arr_start, 1);
        @(negedge clk);
        arr_busy = 1'b1;
        #1 chk("rst_seq_in_wait", job_busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        arr_busy = 1'b0;
        rst_n = 1'b1;
        run_job(mk(1, 2, 2, 16'h0700, 16'h0800, 16'h0900, 0, 1, 0, 0), st, er);
        chk("post_reset_starts", st, 4);

        for (int i = 0; i < 12; i++) begin
            rj = mk($urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(3, 0),
                    16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(3, 0), $urandom_range(3, 0), 0, 0);
            run_job(rj, st, er);
            chk("rand_starts", st, rj.exp_starts);
            chk("rand_err", er, rj.exp_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
